// File: rtl/timer_request_ctrl_if.sv
// Bundle of request, timer and measurement signals between the controller and its environment.
interface timer_request_ctrl_if;
    localparam int unsigned DW = 32;

    // delay request channel
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_cycles;
    logic          done_pulse;
    logic          wait_err;
    // timer delay channel
    logic          start_counter;
    logic [DW-1:0] timer_wait;
    logic          time_count_done;
    // latency measurement channel
    logic          meas_start;
    logic          meas_end;
    logic          start_counter_compare;
    logic          end_counter_compare;
    logic [DW-1:0] timer_compare;
    logic          time_compare_over;
    logic          lat_valid;
    logic [DW-1:0] lat_cycles;
    logic          lat_timeout;
    logic          busy;

    // Environment view: issues requests/events and models the timer.
    modport master (
        output req_valid, req_cycles, time_count_done,
        output meas_start, meas_end, timer_compare, time_compare_over,
        input  req_ready, done_pulse, wait_err, start_counter, timer_wait,
        input  start_counter_compare, end_counter_compare,
        input  lat_valid, lat_cycles, lat_timeout, busy
    );

    // Controller view.
    modport slave (
        input  req_valid, req_cycles, time_count_done,
        input  meas_start, meas_end, timer_compare, time_compare_over,
        output req_ready, done_pulse, wait_err, start_counter, timer_wait,
        output start_counter_compare, end_counter_compare,
        output lat_valid, lat_cycles, lat_timeout, busy
    );
endinterface

// File: rtl/timer_request_ctrl.sv
// Initiator-side controller for the cycle timer: guarded delay waits plus
// bracketed latency measurements, run by two independent FSMs.
module timer_request_ctrl #(
    parameter logic [31:0] COMPARE_OVER = 32'd100000000,
    parameter logic [31:0] WAIT_SLACK   = 32'd16
) (
    input  logic                 clk,
    input  logic                 rst,
    timer_request_ctrl_if.slave  bus
);
    localparam int unsigned CW  = 32;
    localparam int unsigned CW1 = CW + 1;

    typedef enum logic [1:0] {W_IDLE, W_RUN, W_DONE} wait_state_e;
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_HOLD} meas_state_e;

    wait_state_e   w_state_q, w_state_d;
    meas_state_e   m_state_q, m_state_d;

    logic [CW-1:0] wdog_q, wdog_d;
    logic [CW-1:0] limit_q, limit_d;
    logic [CW-1:0] timer_wait_q, timer_wait_d;
    logic          req_ready_q, req_ready_d;
    logic          start_counter_q, start_counter_d;
    logic          done_pulse_q, done_pulse_d;
    logic          wait_err_q, wait_err_d;

    logic          hold_q, hold_d;
    logic          scc_q, scc_d;
    logic          ecc_q, ecc_d;
    logic          lat_valid_q, lat_valid_d;
    logic [CW-1:0] lat_cycles_q, lat_cycles_d;
    logic          lat_timeout_q, lat_timeout_d;
    logic          busy_q, busy_d;

    logic [CW:0]   limit_sum_c;
    logic          wdog_fire_c;

    // Wait FSM: next state, watchdog and timer-side outputs.
    always_comb begin
        w_state_d    = w_state_q;
        wdog_d       = wdog_q;
        limit_d      = limit_q;
        timer_wait_d = timer_wait_q;
        done_pulse_d = 1'b0;
        wait_err_d   = 1'b0;
        limit_sum_c  = CW1'(bus.req_cycles) + CW1'(WAIT_SLACK);
        // Fires on the limit-th cycle of the wait (wdog counts completed cycles).
        wdog_fire_c  = (CW1'(wdog_q) + CW1'(1)) >= CW1'(limit_q);

        unique case (w_state_q)
            W_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    w_state_d    = W_RUN;
                    timer_wait_d = bus.req_cycles;
                    wdog_d       = '0;
                    limit_d      = limit_sum_c[CW] ? '1 : limit_sum_c[CW-1:0];
                end
            end
            W_RUN: begin
                wdog_d = wdog_q + CW'(1);
                if (bus.time_count_done) begin
                    w_state_d    = W_DONE;
                    done_pulse_d = 1'b1;
                end else if (wdog_fire_c) begin
                    w_state_d    = W_DONE;
                    done_pulse_d = 1'b1;
                    wait_err_d   = 1'b1;
                end
            end
            W_DONE: begin
                w_state_d = W_IDLE;
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase

        if (w_state_d != W_RUN) begin
            timer_wait_d = '0;
        end
        start_counter_d = (w_state_d == W_RUN);
        req_ready_d     = (w_state_d == W_IDLE);
    end

    // Measure FSM: start/end pulses to the timer and result capture.
    always_comb begin
        m_state_d     = m_state_q;
        hold_d        = 1'b0;
        scc_d         = 1'b0;
        ecc_d         = 1'b0;
        lat_valid_d   = 1'b0;
        lat_cycles_d  = lat_cycles_q;
        lat_timeout_d = lat_timeout_q;

        unique case (m_state_q)
            M_IDLE: begin
                if (bus.meas_start) begin
                    m_state_d = M_RUN;
                    scc_d     = 1'b1;
                end
            end
            M_RUN: begin
                if (bus.time_compare_over) begin
                    m_state_d     = M_HOLD;
                    lat_cycles_d  = COMPARE_OVER;
                    lat_timeout_d = 1'b1;
                    lat_valid_d   = 1'b1;
                    ecc_d         = 1'b1;
                end else if (bus.meas_end) begin
                    m_state_d     = M_HOLD;
                    lat_cycles_d  = bus.timer_compare;
                    lat_timeout_d = 1'b0;
                    lat_valid_d   = 1'b1;
                    ecc_d         = 1'b1;
                end
            end
            M_HOLD: begin
                // First HOLD cycle carries the result pulse; second is the timer cooldown.
                if (hold_q) begin
                    m_state_d = M_IDLE;
                end else begin
                    hold_d = 1'b1;
                end
            end
            default: begin
                m_state_d = M_IDLE;
            end
        endcase

        busy_d = (w_state_d != W_IDLE) || (m_state_d != M_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q       <= W_IDLE;
            m_state_q       <= M_IDLE;
            wdog_q          <= '0;
            limit_q         <= '0;
            timer_wait_q    <= '0;
            req_ready_q     <= 1'b0;
            start_counter_q <= 1'b0;
            done_pulse_q    <= 1'b0;
            wait_err_q      <= 1'b0;
            hold_q          <= 1'b0;
            scc_q           <= 1'b0;
            ecc_q           <= 1'b0;
            lat_valid_q     <= 1'b0;
            lat_cycles_q    <= '0;
            lat_timeout_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            w_state_q       <= w_state_d;
            m_state_q       <= m_state_d;
            wdog_q          <= wdog_d;
            limit_q         <= limit_d;
            timer_wait_q    <= timer_wait_d;
            req_ready_q     <= req_ready_d;
            start_counter_q <= start_counter_d;
            done_pulse_q    <= done_pulse_d;
            wait_err_q      <= wait_err_d;
            hold_q          <= hold_d;
            scc_q           <= scc_d;
            ecc_q           <= ecc_d;
            lat_valid_q     <= lat_valid_d;
            lat_cycles_q    <= lat_cycles_d;
            lat_timeout_q   <= lat_timeout_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.req_ready             = req_ready_q;
    assign bus.done_pulse            = done_pulse_q;
    assign bus.wait_err              = wait_err_q;
    assign bus.start_counter         = start_counter_q;
    assign bus.timer_wait            = timer_wait_q;
    assign bus.start_counter_compare = scc_q;
    assign bus.end_counter_compare   = ecc_q;
    assign bus.lat_valid             = lat_valid_q;
    assign bus.lat_cycles            = lat_cycles_q;
    assign bus.lat_timeout           = lat_timeout_q;
    assign bus.busy                  = busy_q;

endmodule

// File: tb/tb_timer_request_ctrl.sv
// Directed bench for timer_request_ctrl with a small cycle-timer model on the wait channel.
module tb_timer_request_ctrl;
    localparam logic [31:0] CMP_OVER = 32'd777;

    logic        clk;
    logic        rst;
    logic        model_en;
    logic [31:0] tcnt;
    int          total;
    int          bad;

    timer_request_ctrl_if bus();

    timer_request_ctrl #(
        .COMPARE_OVER (CMP_OVER),
        .WAIT_SLACK   (32'd16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Timer model: done on the (timer_wait+1)-th cycle of start_counter high.
    always_ff @(posedge clk) begin
        if (rst || !bus.start_counter) tcnt <= '0;
        else                           tcnt <= tcnt + 32'd1;
    end
    assign bus.time_count_done = model_en && bus.start_counter && (tcnt == bus.timer_wait);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until done_pulse; returns start_counter-high cycles seen since entry (inclusive).
    task automatic wait_done(input int hi_init, output int hi, output logic found);
        hi    = hi_init;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.done_pulse) begin
                found = 1'b1;
                break;
            end
            if (bus.start_counter) hi++;
        end
    endtask

    int   hi;
    logic found;
    int   hi_run;
    int   lo_run;
    int   dones;
    logic prev;
    logic seen_hi;

    initial begin
        clk = 1'b0; rst = 1'b1; model_en = 1'b1; total = 0; bad = 0;
        bus.req_valid = 1'b0; bus.req_cycles = '0;
        bus.meas_start = 1'b0; bus.meas_end = 1'b0;
        bus.timer_compare = '0; bus.time_compare_over = 1'b0;

        // reset state
        tick(); tick(); tick();
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_sc", bus.start_counter, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_lat", bus.lat_cycles, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", bus.req_ready, 1);

        // normal wait: req_cycles=10, timer done after 11 cycles
        bus.req_valid = 1'b1; bus.req_cycles = 32'd10;
        tick();
        bus.req_valid = 1'b0;
        chk("t1_sc_rise", bus.start_counter, 1);
        chk("t1_twait", bus.timer_wait, 10);
        chk("t1_ready_lo", bus.req_ready, 0);
        chk("t1_busy", bus.busy, 1);
        wait_done(1, hi, found);
        chk("t1_found", found, 1);
        chk("t1_hi_len", hi, 11);
        chk("t1_err", bus.wait_err, 0);
        chk("t1_sc_drop", bus.start_counter, 0);
        chk("t1_ready_d1", bus.req_ready, 0);
        tick();
        chk("t1_ready_d2", bus.req_ready, 1);
        chk("t1_pulse_once", bus.done_pulse, 0);

        // watchdog: req_cycles=5, timer never completes -> 21 cycles high
        model_en = 1'b0;
        bus.req_valid = 1'b1; bus.req_cycles = 32'd5;
        tick();
        bus.req_valid = 1'b0;
        wait_done(1, hi, found);
        chk("t2_found", found, 1);
        chk("t2_hi_len", hi, 21);
        chk("t2_err", bus.wait_err, 1);
        chk("t2_sc_drop", bus.start_counter, 0);
        tick();
        model_en = 1'b1;

        // back-to-back requests with req_valid held
        bus.req_valid = 1'b1; bus.req_cycles = 32'd3;
        hi_run = 0; lo_run = 0; dones = 0; prev = 1'b0; seen_hi = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.start_counter) begin
                if (!prev && seen_hi) chk("t3_gap", lo_run, 2);
                hi_run++; lo_run = 0; seen_hi = 1'b1;
            end else begin
                if (prev) begin
                    chk("t3_hi_len", hi_run, 4);
                    hi_run = 0;
                end
                lo_run++;
            end
            prev = bus.start_counter;
            if (bus.done_pulse) begin
                dones++;
                if (dones == 3) begin
                    bus.req_valid = 1'b0;
                    break;
                end
            end
        end
        chk("t3_dones", dones, 3);
        tick(); tick();
        chk("t3_idle", bus.busy, 0);

        // measurement ended by meas_end 100 cycles after start
        bus.meas_start = 1'b1;
        tick();
        bus.meas_start = 1'b0;
        chk("t4_scc", bus.start_counter_compare, 1);
        chk("t4_busy", bus.busy, 1);
        tick();
        chk("t4_scc_once", bus.start_counter_compare, 0);
        for (int i = 0; i < 98; i++) tick();
        bus.meas_end = 1'b1; bus.timer_compare = 32'd100;
        tick();
        bus.meas_end = 1'b0;
        chk("t4_valid", bus.lat_valid, 1);
        chk("t4_cycles", bus.lat_cycles, 100);
        chk("t4_tmo", bus.lat_timeout, 0);
        chk("t4_ecc", bus.end_counter_compare, 1);
        tick();
        chk("t4_valid_once", bus.lat_valid, 0);
        chk("t4_ecc_once", bus.end_counter_compare, 0);
        chk("t4_hold_cycles", bus.lat_cycles, 100);
        tick();
        chk("t4_idle", bus.busy, 0);

        // timeout coinciding with meas_end; restarts ignored in RUN/HOLD
        bus.meas_start = 1'b1;
        tick();
        bus.meas_start = 1'b0;
        tick(); tick();
        bus.meas_start = 1'b1;
        tick();
        bus.meas_start = 1'b0;
        chk("t5_run_ignore", bus.start_counter_compare, 0);
        bus.time_compare_over = 1'b1; bus.meas_end = 1'b1; bus.timer_compare = 32'd55;
        tick();
        bus.time_compare_over = 1'b0; bus.meas_end = 1'b0;
        chk("t5_valid", bus.lat_valid, 1);
        chk("t5_cycles", bus.lat_cycles, CMP_OVER);
        chk("t5_tmo", bus.lat_timeout, 1);
        bus.meas_start = 1'b1;
        tick();
        chk("t5_hold_ignore1", bus.start_counter_compare, 0);
        tick();
        chk("t5_hold_ignore2", bus.start_counter_compare, 0);
        chk("t5_idle", bus.busy, 0);
        tick();
        bus.meas_start = 1'b0;
        chk("t5_rearm", bus.start_counter_compare, 1);
        bus.meas_end = 1'b1; bus.timer_compare = 32'd7;
        tick();
        bus.meas_end = 1'b0;
        chk("t5_cycles2", bus.lat_cycles, 7);
        chk("t5_tmo2", bus.lat_timeout, 0);
        tick(); tick();

        // reset in the middle of a long wait
        bus.req_valid = 1'b1; bus.req_cycles = 32'd1000;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_twait", bus.timer_wait, 1000);
        rst = 1'b1;
        tick();
        chk("t6_sc", bus.start_counter, 0);
        chk("t6_twait0", bus.timer_wait, 0);
        chk("t6_ready", bus.req_ready, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_lat0", bus.lat_cycles, 0);
        tick();
        chk("t6_no_done", bus.done_pulse, 0);
        rst = 1'b0;
        tick();
        chk("t6_ready_back", bus.req_ready, 1);
        bus.req_valid = 1'b1; bus.req_cycles = 32'd2;
        tick();
        bus.req_valid = 1'b0;
        chk("t6_sc_new", bus.start_counter, 1);
        chk("t6_twait_new", bus.timer_wait, 2);
        wait_done(1, hi, found);
        chk("t6_found", found, 1);
        chk("t6_hi_len", hi, 3);
        chk("t6_err", bus.wait_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/timer_request_ctrl.md
# timer_request_ctrl

Initiator-side controller for the cycle timer block (`start_counter`/`timer_wait`/`time_count_done` delay channel and `start_counter_compare`/`end_counter_compare`/`timer_compare` measurement channel). It accepts delay requests over a valid/ready handshake, drives the timer's wait inputs until the timer reports completion, and guards each wait with a local watchdog. It also brackets latency measurements between two event pulses, typically UART TX-sent and RX-received, and reports the measured cycle count or a timeout.

## Interface
Parameters:
- `COMPARE_OVER`, 32'd100000000: timer measurement timeout in cycles; must equal the timer's setting.
- `WAIT_SLACK`, 32'd16: extra cycles allowed beyond `req_cycles` before the wait watchdog fires.

Ports:
- `clk` input 1: single clock, 100 MHz.
- `rst` input 1: reset, synchronous, active-high.
- `req_valid` input 1: delay request valid.
- `req_ready` output 1: controller can accept a delay request.
- `req_cycles` input 32: requested wait, in clock cycles.
- `done_pulse` output 1: one-cycle pulse when a wait ends.
- `wait_err` output 1: qualifies `done_pulse`; 1 means the watchdog aborted the wait.
- `start_counter` output 1: to timer; held high for the whole wait.
- `timer_wait` output 32: to timer; wait length.
- `time_count_done` input 1: from timer; wait reached.
- `meas_start` input 1: pulse that starts a latency measurement.
- `meas_end` input 1: pulse that ends a latency measurement.
- `start_counter_compare` output 1: to timer; one-cycle start pulse.
- `end_counter_compare` output 1: to timer; one-cycle end pulse.
- `timer_compare` input 32: from timer; running measurement count.
- `time_compare_over` input 1: from timer; measurement timeout.
- `lat_valid` output 1: one-cycle pulse, result available.
- `lat_cycles` output 32: measured cycles, held until the next result.
- `lat_timeout` output 1: qualifies `lat_cycles`; held with it.
- `busy` output 1: either FSM is outside its idle state.

## Operation
- All outputs are registered. Under `rst` every output is 0 and both FSMs are idle.
- Wait FSM states: W_IDLE, W_RUN, W_DONE.
  - W_IDLE: `req_ready`=1, `start_counter`=0, `timer_wait`=0.
  - W_IDLE → W_RUN on `req_valid && req_ready`. On this transition, latch `req_cycles` into `timer_wait`, clear the watchdog counter, and compute `limit = req_cycles + WAIT_SLACK` in 33 bits, saturating at 2^32−1 with no wrap.
  - W_RUN: `start_counter`=1 and `timer_wait` stable. The watchdog counter increments every cycle.
  - W_RUN → W_DONE when `time_count_done`=1 (`wait_err`=0), or when watchdog == limit with `time_count_done`=0 (`wait_err`=1). If both occur in the same cycle, completion wins.
  - W_DONE: `start_counter`=0, `done_pulse`=1 for exactly one cycle. Always returns to W_IDLE next cycle.
- Measure FSM states: M_IDLE, M_RUN, M_HOLD.
  - M_IDLE → M_RUN on `meas_start`, with `start_counter_compare` pulsed for one cycle.
  - M_RUN on `meas_end` and not `time_compare_over`: capture `lat_cycles` = `timer_compare` as sampled that cycle, `lat_timeout`=0.
  - M_RUN on `time_compare_over` (this takes priority when it coincides with `meas_end`): `lat_cycles` = `COMPARE_OVER`, `lat_timeout`=1.
  - Either M_RUN exit pulses `end_counter_compare` and `lat_valid` on the next cycle, then enters M_HOLD.
  - M_HOLD: one cooldown cycle so the timer returns to idle, then M_IDLE.
  - `meas_start` is ignored outside M_IDLE. `meas_end` is ignored outside M_RUN.
- The two FSMs are independent and may run concurrently.
- `busy` = (wait FSM ≠ W_IDLE) | (measure FSM ≠ M_IDLE), registered.

## Timing
- After `rst` deasserts: `req_ready`=1 from the first clock edge.
- Request accepted at cycle T: `start_counter`=1, `timer_wait` valid, and `req_ready`=0 from T+1.
- `time_count_done` sampled high at cycle D: `start_counter`=0 and `done_pulse`=1 at D+1; `req_ready`=1 at D+2.
  - Back-to-back requests are therefore spaced by at least 2 idle cycles of `start_counter`, which guarantees the timer re-arms.
- `meas_start` at cycle S: `start_counter_compare` high at S+1 only.
- `meas_end` or timeout at cycle E: `lat_cycles`, `lat_timeout`, `lat_valid` and `end_counter_compare` at E+1; M_IDLE at E+3. A `meas_start` at E+2 is dropped.
- `rst` asserted mid-wait or mid-measure: the next edge forces idle and all outputs to 0, with no `done_pulse` or `lat_valid`.
- `req_cycles`=0 is legal; the request completes on the timer's first done.

## Test plan
- Reset, then request `req_cycles`=10 with a timer model that asserts done 11 cycles after start → `start_counter` high for 11 cycles, `done_pulse`=1 with `wait_err`=0, `req_ready` back 2 cycles later.
- Request `req_cycles`=5 with `time_count_done` stuck at 0 → `done_pulse` with `wait_err`=1 exactly 21 cycles after accept, `start_counter` dropped.
- Hold `req_valid` continuously with `req_cycles`=3 → successive `start_counter` high periods separated by exactly 2 low cycles; no request lost.
- `meas_start`, then `meas_end` 100 cycles later with `timer_compare`=100 → `lat_valid` pulse, `lat_cycles`=100, `lat_timeout`=0, one `end_counter_compare` pulse.
- `meas_start`, then `time_compare_over` and `meas_end` in the same cycle → `lat_cycles`=`COMPARE_OVER`, `lat_timeout`=1; a second `meas_start` during M_RUN or M_HOLD is ignored.
- Assert `rst` mid-wait with `timer_wait`=1000 → all outputs 0 next cycle, no `done_pulse`; a new request is accepted after reset releases.
